// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory-wait stall with timeout, jump flush, load-use bubble.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_WIDTH    = 16,
  parameter int RADDR_WIDTH = 5,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [RADDR_WIDTH-1:0] id_rs1_addr_in,
  input  logic                   id_rs1_read_in,
  input  logic [RADDR_WIDTH-1:0] id_rs2_addr_in,
  input  logic                   id_rs2_read_in,
  input  logic                   ex_is_load_in,
  input  logic [RADDR_WIDTH-1:0] ex_rd_in,
  input  logic                   ex_jump_in,
  input  logic [ADDR_WIDTH-1:0]  ex_jump_addr_in,
  input  logic                   mem_req_in,
  input  logic                   mem_ready_in,
  output logic [5:0]             stall_out,
  output logic                   jump_flush_out,
  output logic [ADDR_WIDTH-1:0]  jump_addr_out,
  output logic                   bus_err_out,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]            stall_cycles_out,
  output logic [31:0]            flush_count_out,
`endif
  output logic                   busy_out
);

  // Handshake: mem_req_in with mem_ready_in high completes the access in that
  // cycle; req without ready holds PC..MEM until ready or timeout.

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_LOAD = 6'b000111;

  state_t              state, state_next;
  logic [TO_WIDTH-1:0] wait_cnt, wait_cnt_next;
  logic                bus_err_q, bus_err_next;
  logic                load_use, timeout_hit, mem_hold;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state     <= RUN;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      bus_err_q <= bus_err_next;
    end
  end

  always_comb begin
    load_use = ex_is_load_in && (ex_rd_in != '0) &&
               ((id_rs1_read_in && (id_rs1_addr_in == ex_rd_in)) ||
                (id_rs2_read_in && (id_rs2_addr_in == ex_rd_in)));
    timeout_hit = (state == MEM_WAIT) && !mem_ready_in &&
                  (wait_cnt == TO_WIDTH'(MEM_TIMEOUT));
    if (state == RUN) mem_hold = mem_req_in && !mem_ready_in;
    else              mem_hold = !mem_ready_in && !timeout_hit;
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    bus_err_next  = 1'b0;
    case (state)
      RUN: begin
        if (mem_req_in && !mem_ready_in) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = TO_WIDTH'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_in) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (timeout_hit) begin
          state_next    = RUN;
          wait_cnt_next = '0;
          bus_err_next  = 1'b1;
        end else if (wait_cnt != '1) begin
          wait_cnt_next = wait_cnt + TO_WIDTH'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Mealy outputs; a jump arriving during a memory wait is simply not issued,
  // the held EXE stage re-presents it on the release cycle.
  always_comb begin
    stall_out      = '0;
    jump_flush_out = 1'b0;
    jump_addr_out  = '0;
    bus_err_out    = 1'b0;
    busy_out       = 1'b0;
    if (!reset_in) begin
      bus_err_out = bus_err_q;
      busy_out    = (state != RUN);
      if (mem_hold) begin
        stall_out = STALL_MEM;
      end else if (ex_jump_in) begin
        jump_flush_out = 1'b1;
        jump_addr_out  = ex_jump_addr_in;
      end else if (load_use) begin
        stall_out = STALL_LOAD;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stall_cycles_out <= '0;
      flush_count_out  <= '0;
    end else begin
      if (stall_out != '0) stall_cycles_out <= stall_cycles_out + 32'd1;
      if (jump_flush_out)  flush_count_out  <= flush_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares the Mealy and registered outputs.
module tb_pipe_ctrl;

  localparam int RW = 5;
  localparam int AW = 32;
  localparam int EW = 6 + 1 + AW + 1 + 1;
  localparam logic [5:0] S_MEM = 6'b011111;
  localparam logic [5:0] S_LU  = 6'b000111;
  localparam logic [5:0] S_NO  = 6'b000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1, rs2, rd;
  logic          rs1r, rs2r, ld, jmp, req, rdy;
  logic [AW-1:0] jaddr;
  logic [5:0]    stall;
  logic          flush, berr, busy;
  logic [AW-1:0] jaddr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cycles, flush_count;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;

  pipe_ctrl #(.MEM_TIMEOUT(3), .TO_WIDTH(16), .RADDR_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk_in          (clk),
    .reset_in        (rst),
    .id_rs1_addr_in  (rs1),
    .id_rs1_read_in  (rs1r),
    .id_rs2_addr_in  (rs2),
    .id_rs2_read_in  (rs2r),
    .ex_is_load_in   (ld),
    .ex_rd_in        (rd),
    .ex_jump_in      (jmp),
    .ex_jump_addr_in (jaddr),
    .mem_req_in      (req),
    .mem_ready_in    (rdy),
    .stall_out       (stall),
    .jump_flush_out  (flush),
    .jump_addr_out   (jaddr_o),
    .bus_err_out     (berr),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles_out(stall_cycles),
    .flush_count_out (flush_count),
`endif
    .busy_out        (busy)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // driver: one vector per cycle, inputs set 1 ns after the rising edge
  task automatic vec(input logic r,
                     input logic a1r, input logic [RW-1:0] a1,
                     input logic a2r, input logic [RW-1:0] a2,
                     input logic l, input logic [RW-1:0] d,
                     input logic j, input logic [AW-1:0] ja,
                     input logic q, input logic y,
                     input logic [5:0] e_stall, input logic e_flush,
                     input logic [AW-1:0] e_addr, input logic e_err, input logic e_busy);
    @(posedge clk);
    #1;
    rst = r; rs1r = a1r; rs1 = a1; rs2r = a2r; rs2 = a2;
    ld = l; rd = d; jmp = j; jaddr = ja; req = q; rdy = y;
    exp_q.push_back({e_stall, e_flush, e_addr, e_err, e_busy});
  endtask

  task automatic idle(input logic e_err);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 0,0, S_NO,0,32'h0,e_err,0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, g;
      e = exp_q.pop_front();
      g = {stall, flush, jaddr_o, berr, busy};
      n_vec++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got stall=%b flush=%b addr=%h err=%b busy=%b, want stall=%b flush=%b addr=%h err=%b busy=%b",
                 n_vec, g[EW-1 -: 6], g[EW-7], g[AW+1:2], g[1], g[0],
                 e[EW-1 -: 6], e[EW-7], e[AW+1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; rs1r = 0; rs2r = 0;
    ld = 0; jmp = 0; req = 0; rdy = 0; jaddr = '0;

    // T1: reset held with random inputs forces every output low
    for (int i = 0; i < 3; i++)
      vec(1, 1'($urandom_range(0,1)), RW'($urandom_range(0,31)),
             1'($urandom_range(0,1)), RW'($urandom_range(0,31)),
             1'($urandom_range(0,1)), RW'($urandom_range(0,31)),
             1'($urandom_range(0,1)), 32'($urandom),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
          S_NO,0,32'h0,0,0);
    idle(0);

    // T2: load-use on rs2, cleared load, rd=0, rs1 hit, rs1 not read
    vec(0, 0,0, 1,5, 1,5, 0,32'h0, 0,0, S_LU,0,32'h0,0,0);
    vec(0, 0,0, 1,5, 0,5, 0,32'h0, 0,0, S_NO,0,32'h0,0,0);
    vec(0, 0,0, 1,0, 1,0, 0,32'h0, 0,0, S_NO,0,32'h0,0,0);
    vec(0, 1,7, 0,0, 1,7, 0,32'h0, 0,0, S_LU,0,32'h0,0,0);
    vec(0, 0,7, 0,0, 1,7, 0,32'h0, 0,0, S_NO,0,32'h0,0,0);

    // T3: jump beats load-use
    vec(0, 0,0, 1,5, 1,5, 1,32'h80, 0,0, S_NO,1,32'h80,0,0);
    // ready without request in RUN is ignored
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 0,1, S_NO,0,32'h0,0,0);

    // T4: short wait, ready on second MEM_WAIT cycle
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,1, S_NO,0,32'h0,0,1);
    idle(0);
    // ready arriving exactly at wait_cnt==MEM_TIMEOUT wins: no bus error
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,1, S_NO,0,32'h0,0,1);
    idle(0);

    // T5: timeout releases stall, bus_err pulses once the following cycle
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_NO,0,32'h0,0,1);
    idle(1);
    idle(0);

    // T6: jump held during wait, issued on the ready cycle
    vec(0, 0,0, 0,0, 0,0, 1,32'h44, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 1,32'h44, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 1,32'h44, 1,1, S_NO,1,32'h44,0,1);
    idle(0);

    // jump issues on the timeout release cycle too
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 1,32'h100, 1,0, S_NO,1,32'h100,0,1);
    idle(1);
    idle(0);

    // reset during a wait that would have timed out: no bus_err
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(0, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_MEM,0,32'h0,0,1);
    vec(1, 0,0, 0,0, 0,0, 0,32'h0, 1,0, S_NO,0,32'h0,0,0);
    idle(0);
    idle(0);

    // mem wait outranks load-use; load-use shows on the ready cycle
    vec(0, 1,9, 0,0, 1,9, 0,32'h0, 1,0, S_MEM,0,32'h0,0,0);
    vec(0, 1,9, 0,0, 1,9, 0,32'h0, 1,1, S_LU,0,32'h0,0,1);
    idle(0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
